// File: rtl/inst_encoder_pkg.sv
// Shared RV32I encoding definitions: opcodes, instruction classes and encoder session states.
// Latency: none (definitions only); backpressure: n/a.
package inst_encoder_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    CLS_REG    = 4'd0,
    CLS_IMM    = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8
  } inst_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } enc_state_e;

  // funct7 as the decoder sees it: only bit 5 carries meaning.
  function automatic logic [6:0] funct7_alt(input logic alt);
    return {1'b0, alt, 5'b00000};
  endfunction

endpackage

// File: rtl/inst_encoder_enc_fields.sv
// Pure combinational field-to-instruction-word encoder, the inverse of the decoder.
// Latency: 0 cycles; backpressure: none, flags illegal class or misaligned branch/jump targets.
module enc_fields
  import inst_encoder_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (cls)
      CLS_REG:    word = {funct7_alt(alt), rs2, rs1, funct3, rd, OPC_OP};
      CLS_IMM: begin
        // Shift-immediates reuse the funct7 slot for the arithmetic/logical select.
        if (funct3 == 3'b001 || funct3 == 3'b101)
          word = {funct7_alt(alt), imm[4:0], rs1, funct3, rd, OPC_OP_IMM};
        else
          word = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
      end
      CLS_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      CLS_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      CLS_BRANCH: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
        illegal = imm[0];
      end
      CLS_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        illegal = imm[0];
      end
      CLS_JALR:   word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      CLS_LUI:    word = {imm[31:12], rd, OPC_LUI};
      CLS_AUIPC:  word = {imm[31:12], rd, OPC_AUIPC};
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Session-based instruction encoder writing one encoded word per accepted field set to memory.
// Latency: 1 cycle input-to-mem_we; backpressure: outputs hold while mem_ready is low, in_ready drops.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_class,
  input  logic [2:0]                   in_funct3,
  input  logic                         in_alt,
  input  logic [4:0]                   in_rs1,
  input  logic [4:0]                   in_rs2,
  input  logic [4:0]                   in_rd,
  input  logic [31:0]                  in_imm,
  output logic                         mem_we,
  input  logic                         mem_ready,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_wdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy,
  output logic                         full,
  output logic                         err
);

  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);

  enc_state_e   state_q, state_d;
  logic [31:0]  enc_word;
  logic         enc_illegal;
  logic         accept, mem_done;
  logic [CW-1:0] count_d;
  logic [CW:0]  occupancy;

  enc_fields u_enc_fields (
    .cls     (in_class),
    .funct3  (in_funct3),
    .alt     (in_alt),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .rd      (in_rd),
    .imm     (in_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign mem_done  = mem_we & mem_ready;
  assign accept    = in_valid & in_ready;
  assign count_d   = count + CW'(mem_done);
  // Words already written plus the one sitting in the output register.
  assign occupancy = (CW + 1)'(count) + (CW + 1)'(mem_we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_RUN;
        ST_RUN:  if ({1'b0, count_d} == DEPTH_W) state_d = ST_FULL;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy     = (state_q == ST_RUN);
    full     = (state_q == ST_FULL);
    in_ready = busy && (!mem_we || mem_ready) && (occupancy < DEPTH_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= 32'h0;
      count     <= '0;
      err       <= 1'b0;
    end else if (clear) begin
      // A pending word is dropped here; memory never sees it.
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= 32'h0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      count <= count_d;
      if (mem_done) mem_addr <= mem_addr + 32'd4;
      if (accept && !enc_illegal) begin
        mem_we    <= 1'b1;
        mem_wdata <= enc_word;
      end else if (mem_done) begin
        mem_we <= 1'b0;
      end
      if (accept && enc_illegal) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder (DEPTH=4, BASE_ADDR=0): encodings, stalls, full, errors, clear and reset.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_class = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_alt = 1'b0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_imm = '0;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  count;
  logic        busy, full, err;

  int total = 0;
  int bad = 0;
  int writes = 0;
  int w0;

  inst_encoder #(.BASE_ADDR(32'h0), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_imm(in_imm), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
    .busy(busy), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we && mem_ready) writes <= writes + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one field set and hold it until accepted or max_wait cycles pass.
  task automatic offer(input string tag, input logic [3:0] c, input logic [2:0] f3, input logic alt,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic [31:0] imm, input int max_wait);
    int n;
    in_class = c; in_funct3 = f3; in_alt = alt;
    in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_imm = imm;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < max_wait) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_count", 32'(count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_full", 32'(full), 0);
    check("rst_err", 32'(err), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Session A: individual encodings, then fill to DEPTH
    w0 = writes;
    start = 1'b1; tick(); start = 1'b0;
    check("a_busy", 32'(busy), 1);
    check("a_in_ready", 32'(in_ready), 1);
    offer("reg", 4'd0, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 20);
    check("reg_we", 32'(mem_we), 1);
    check("reg_dat", mem_wdata, 32'h002081B3);
    check("reg_addr", mem_addr, 32'h0);
    tick();
    check("reg_count", 32'(count), 1);
    check("reg_we_drop", 32'(mem_we), 0);
    offer("imm", 4'd1, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF, 20);
    check("imm_dat", mem_wdata, 32'hFFF00093);
    check("imm_addr", mem_addr, 32'h4);
    offer("store", 4'd3, 3'b010, 1'b0, 5'd2, 5'd5, 5'd0, 32'd8, 0);
    check("store_dat", mem_wdata, 32'h00512423);
    check("store_addr", mem_addr, 32'h8);
    offer("jal", 4'd5, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'd8, 0);
    check("jal_dat", mem_wdata, 32'h008000EF);
    check("jal_addr", mem_addr, 32'hC);
    check("jal_in_ready", 32'(in_ready), 0);
    tick();
    check("a_full", 32'(full), 1);
    check("a_busy_full", 32'(busy), 0);
    check("a_count", 32'(count), 4);
    in_class = 4'd0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("a_extra_we", 32'(mem_we), 0);
      check("a_extra_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    check("a_writes", 32'(writes - w0), 4);
    check("a_count_hold", 32'(count), 4);
    start = 1'b1; tick(); start = 1'b0;
    check("a_start_in_full", 32'(full), 1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("a_clear_full", 32'(full), 0);
    check("a_clear_count", 32'(count), 0);
    check("a_clear_addr", mem_addr, 32'h0);

    // Session B: stall with mem_ready low, then back-to-back stream
    w0 = writes;
    start = 1'b1; tick(); start = 1'b0;
    offer("lui", 4'd7, 3'b000, 1'b0, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 20);
    check("lui_dat", mem_wdata, 32'h123452B7);
    check("lui_addr", mem_addr, 32'h0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_we", 32'(mem_we), 1);
      check("stall_dat", mem_wdata, 32'h123452B7);
      check("stall_addr", mem_addr, 32'h0);
      check("stall_in_ready", 32'(in_ready), 0);
    end
    check("stall_writes", 32'(writes - w0), 0);
    mem_ready = 1'b1;
    start = 1'b1;
    offer("srai", 4'd1, 3'b101, 1'b1, 5'd2, 5'd0, 5'd1, 32'd3, 0);
    start = 1'b0;
    check("srai_dat", mem_wdata, 32'h40315093);
    check("srai_addr", mem_addr, 32'h4);
    check("run_start_busy", 32'(busy), 1);
    offer("jalr", 4'd6, 3'b011, 1'b0, 5'd5, 5'd0, 5'd1, 32'd4, 0);
    check("jalr_dat", mem_wdata, 32'h004280E7);
    check("jalr_addr", mem_addr, 32'h8);
    offer("sub", 4'd0, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'h0, 0);
    check("sub_dat", mem_wdata, 32'h402081B3);
    check("sub_addr", mem_addr, 32'hC);
    tick();
    check("b_full", 32'(full), 1);
    check("b_count", 32'(count), 4);
    check("b_writes", 32'(writes - w0), 4);
    clear = 1'b1; tick(); clear = 1'b0;

    // Session C: remaining formats and error handling
    start = 1'b1; tick(); start = 1'b0;
    offer("load", 4'd2, 3'b010, 1'b0, 5'd2, 5'd0, 5'd6, 32'hFFFF_FFFC, 20);
    check("load_dat", mem_wdata, 32'hFFC12303);
    check("load_addr", mem_addr, 32'h0);
    offer("auipc", 4'd8, 3'b000, 1'b0, 5'd0, 5'd0, 5'd2, 32'h0000_1000, 0);
    check("auipc_dat", mem_wdata, 32'h00001117);
    check("auipc_addr", mem_addr, 32'h4);
    check("pre_err", 32'(err), 0);
    offer("cls12", 4'd12, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 0);
    check("cls12_we", 32'(mem_we), 0);
    check("cls12_err", 32'(err), 1);
    check("cls12_count", 32'(count), 2);
    offer("br_odd", 4'd4, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd3, 0);
    check("br_odd_we", 32'(mem_we), 0);
    check("br_odd_count", 32'(count), 2);
    offer("br", 4'd4, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd8, 0);
    check("br_dat", mem_wdata, 32'h00208463);
    check("br_addr", mem_addr, 32'h8);
    check("err_sticky", 32'(err), 1);
    tick();
    check("c_count", 32'(count), 3);
    clear = 1'b1; tick(); clear = 1'b0;
    check("c_clear_err", 32'(err), 0);
    check("c_clear_busy", 32'(busy), 0);

    // Session D: clear (winning over start) with a word pending
    start = 1'b1; tick(); start = 1'b0;
    mem_ready = 1'b0;
    offer("d_reg", 4'd0, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 20);
    check("d_pending_we", 32'(mem_we), 1);
    w0 = writes;
    clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
    check("d_clear_we", 32'(mem_we), 0);
    check("d_clear_count", 32'(count), 0);
    check("d_clear_busy", 32'(busy), 0);
    check("d_clear_addr", mem_addr, 32'h0);
    mem_ready = 1'b1;
    tick();
    check("d_clear_writes", 32'(writes - w0), 0);

    // Reset with a word pending
    start = 1'b1; tick(); start = 1'b0;
    mem_ready = 1'b0;
    offer("r_reg", 4'd0, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 20);
    check("r_pending_we", 32'(mem_we), 1);
    w0 = writes;
    #1 rst_n = 1'b0;
    #1;
    check("r_we", 32'(mem_we), 0);
    check("r_count", 32'(count), 0);
    check("r_busy", 32'(busy), 0);
    check("r_in_ready", 32'(in_ready), 0);
    check("r_wdata", mem_wdata, 32'h0);
    mem_ready = 1'b1;
    tick();
    check("r_writes", 32'(writes - w0), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0, SHALL be the byte address of the first written word.
REQ-002 Parameter DEPTH, default 256, SHALL be the maximum number of words written per session.
REQ-003 clk  input  1  SHALL be the single clock; one clock, all state on rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 start  input  1  SHALL begin a session (IDLE->RUN).
REQ-006 clear  input  1  SHALL abort the session and return to IDLE.
REQ-007 in_valid  input  1 / in_ready  output  1  SHALL form the field-input handshake.
REQ-008 in_class  input  4  SHALL select the format: 0 REG, 1 IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; 9-15 illegal.
REQ-009 in_funct3  input  3 / in_alt  input  1 (funct7[5])  SHALL be the operation selectors.
REQ-010 in_rs1, in_rs2, in_rd  input  5 each  SHALL be the register fields.
REQ-011 in_imm  input  32  SHALL be the sign-extended byte-level immediate, as produced by the decoder.
REQ-012 mem_we  output  1 / mem_ready  input  1  SHALL form the memory-write handshake.
REQ-013 mem_addr  output  32 / mem_wdata  output  32  SHALL be the write address and encoded instruction.
REQ-014 count  output  $clog2(DEPTH+1)  SHALL be the number of words accepted by memory this session.
REQ-015 busy  output  1, full  output  1, err  output  1  SHALL report RUN, FULL and sticky-error status.

Function
REQ-016 Encoding SHALL be the exact inverse of decoding: opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
REQ-017 REG SHALL set funct7 = {1'b0, in_alt, 5'b0}; IMM SHALL use imm[11:0], except funct3 001/101, where bits[31:25] = {1'b0, in_alt, 5'b0} and bits[24:20] = imm[4:0].
REQ-018 STORE SHALL split imm[11:5]/imm[4:0]; BRANCH SHALL place imm[12|10:5|4:1|11]; JAL SHALL place imm[20|10:1|11|19:12]; LUI/AUIPC SHALL use imm[31:12].
REQ-019 JALR SHALL force funct3 = 000; unused register fields SHALL be encoded as zero.
REQ-020 States SHALL be IDLE, RUN and FULL; IDLE->RUN on start, RUN->FULL when count reaches DEPTH, any->IDLE on clear (clear wins over start).
REQ-021 in_ready SHALL equal (state == RUN) && (!mem_we || mem_ready) && (count + pending < DEPTH).
REQ-022 An accepted input SHALL appear on mem_we/mem_addr/mem_wdata on the next cycle (latency 1, one output register).
REQ-023 mem_we, mem_addr and mem_wdata SHALL hold stable while mem_we && !mem_ready.
REQ-024 Back-to-back transfers SHALL sustain one word per cycle when mem_ready is held high.
REQ-025 mem_addr SHALL start at BASE_ADDR and increment by 4 per word accepted by memory.
REQ-026 An illegal class, or a BRANCH/JAL immediate with imm[0] = 1, SHALL be consumed without a write and SHALL set err.
REQ-027 err SHALL be sticky until clear or reset.
REQ-028 clear while mem_we is pending SHALL drop the pending word without a write, and SHALL zero count and the address.
REQ-029 A start in RUN or FULL SHALL be ignored.

Reset
REQ-030 Asserting rst_n low SHALL immediately set state to IDLE and force mem_we = 0, mem_addr = BASE_ADDR, mem_wdata = 0, count = 0, busy = 0, full = 0, err = 0 and in_ready = 0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer with no write issued.

Structure
REQ-032 Opcode constants, class enum and state enum SHALL reside in the shared package, alongside the decoder's opcode definitions.
REQ-033 The pure combinational field-to-word encoder SHALL be a sub-module, enc_fields; the handshake, counter and FSM SHALL reside in inst_encoder.

Verification
REQ-034 REG: rs1=1, rs2=2, rd=3, funct3=0, alt=0 -> mem_wdata 32'h002081B3 at mem_addr BASE_ADDR one cycle after acceptance.
REQ-035 IMM: rd=1, rs1=0, imm=-1, funct3=0 -> 32'hFFF00093; STORE: rs1=2, rs2=5, imm=8, funct3=010 -> 32'h00512423.
REQ-036 JAL: rd=1, imm=8 -> 32'h008000EF; LUI: rd=5, imm=32'h12345000 -> 32'h123452B7.
REQ-037 mem_ready low 3 cycles mid-stream -> outputs stable, in_ready low, no loss or duplication; the decoder fed mem_wdata reproduces every input field.
REQ-038 DEPTH=4, six inputs offered -> four writes at addresses 0, 4, 8 and 12, then full = 1 and in_ready = 0; class 12 or BRANCH with imm=3 -> no write, err = 1.
REQ-039 rst_n or clear asserted while mem_we is pending -> no write, count = 0, state IDLE.
